// File: rtl/gost_pkg.sv
// gost_pkg: constants shared by the GOST (Magma) encrypt and decrypt paths
package gost_pkg;
    localparam int ROUNDS = 32;
    localparam int ROT = 11;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    // Magma S-box rows; entry 0 is the leftmost nibble of each row
    localparam logic [0:15][3:0] SBOX [8] = '{
        64'hC462A5B9E8D703F1,
        64'h68239A5C1E47BD0F,
        64'hB3582FADE174C960,
        64'hC821D4F670A53E9B,
        64'h7F5A816D093EB42C,
        64'h5DF692CAB78143E0,
        64'h8E25691CF4B0DA37,
        64'h17ED05834FA69CB2
    };
endpackage

// File: rtl/gost_round_f.sv
// gost_round_f: GOST round function g(x) = ROL11(S(x + k))
module gost_round_f
    import gost_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] k,
    output logic [31:0] g
);
    logic [31:0] t;
    logic [31:0] s;
    assign t = x + k;
    for (genvar n = 0; n < 8; n++) begin : g_sbox
        assign s[4*n +: 4] = SBOX[n][t[4*n +: 4]];
    end
    assign g = (s << ROT) | (s >> (32 - ROT));
endmodule

// File: rtl/gost_decrypt.sv
// gost_decrypt: iterative GOST (Magma) block decryption, one round per cycle
module gost_decrypt
    import gost_pkg::*;
(
    input  logic         iclk,
    input  logic         irst,
    input  logic         istart,
    input  logic [63:0]  iblock,
    input  logic [255:0] ikey,
    output logic [63:0]  oblock,
    output logic         odone,
    output logic         obusy
);
    state_e state_q, state_d;
    logic [4:0] rnd_q, rnd_d;
    logic [63:0] a_q, a_d;
    logic [255:0] key_q, key_d;
    logic [63:0] oblock_q, oblock_d;
    logic odone_q, odone_d;
    logic obusy_q, obusy_d;
    logic [2:0] kidx;
    logic [31:0] kj;
    logic [31:0] g;
    logic [31:0] mix;
    logic last;
    // Decrypt order: K0..K7 once, then K7..K0 three times; K_j sits at ikey[255-32j -: 32]
    assign kidx = rnd_q[4:3] == 2'b00 ? rnd_q[2:0] : ~rnd_q[2:0];
    assign kj = key_q[{~kidx, 5'd0} +: 32];
    assign mix = g ^ a_q[63:32];
    assign last = rnd_q == 5'(ROUNDS - 1);
    gost_round_f u_round (
        .x (a_q[31:0]),
        .k (kj),
        .g (g)
    );
    always_comb begin
        state_d = state_q;
        rnd_d = rnd_q;
        a_d = a_q;
        key_d = key_q;
        oblock_d = oblock_q;
        odone_d = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = istart ? RUN : IDLE;
                rnd_d = istart ? 5'd0 : rnd_q;
                a_d = istart ? iblock : a_q;
                key_d = istart ? ikey : key_q;
            end
            RUN: begin
                rnd_d = rnd_q + 5'd1;
                a_d = last ? {mix, a_q[31:0]} : {a_q[31:0], mix};
                oblock_d = last ? {mix, a_q[31:0]} : oblock_q;
                state_d = last ? DONE : RUN;
            end
            DONE: begin
                odone_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        obusy_d = state_d != IDLE;
    end
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= IDLE;
            rnd_q <= '0;
            a_q <= '0;
            key_q <= '0;
            oblock_q <= '0;
            odone_q <= 1'b0;
            obusy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q <= rnd_d;
            a_q <= a_d;
            key_q <= key_d;
            oblock_q <= oblock_d;
            odone_q <= odone_d;
            obusy_q <= obusy_d;
        end
    end
    assign oblock = oblock_q;
    assign odone = odone_q;
    assign obusy = obusy_q;
endmodule

// File: doc/gost_decrypt.md
GOST_DECRYPT -- requirements
Module: gost_decrypt

Interface
REQ-001 SHALL have port iclk, input, 1 bit: single clock, all state on rising edge.
REQ-002 SHALL have port irst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port istart, input, 1 bit: start request, sampled only in IDLE.
REQ-004 SHALL have port iblock, input, 64 bits: ciphertext block, {a1[63:32], a0[31:0]}.
REQ-005 SHALL have port ikey, input, 256 bits: key, K0 = ikey[255:224] … K7 = ikey[31:0].
REQ-006 SHALL have port oblock, output, 64 bits: plaintext block, held valid from odone until the next accepted istart.
REQ-007 SHALL have port odone, output, 1 bit: one-cycle completion pulse.
REQ-008 SHALL have port obusy, output, 1 bit: high in RUN and DONE.

Function
REQ-009 SHALL implement an FSM with states IDLE, RUN and DONE, plus a 5-bit round counter rnd.
REQ-010 SHALL, in IDLE with istart=1: latch iblock into the state register, latch ikey, clear rnd to 0, and move to RUN.
REQ-011 SHALL, in RUN, apply exactly one round per cycle using key Kj, where j = rnd for rnd<8 and j = 7-(rnd mod 8) for rnd>=8.
REQ-012 SHALL define round g(x) = ROL11(S(x + Kj mod 2^32)), where S substitutes eight 4-bit nibbles and nibble n uses S-box row n (nibble 0 = bits [3:0]).
REQ-013 SHALL compute rounds 0..30 as (a1,a0) <- (a0, g(a0) xor a1).
REQ-014 SHALL compute round 31 without swap as (a1,a0) <- (g(a0) xor a1, a0), then move to DONE.
REQ-015 SHALL, in DONE, assert odone for exactly one cycle with oblock = {a1,a0}, then return to IDLE.
REQ-016 SHALL place odone exactly 33 cycles after the rising edge that sampled istart.
REQ-017 SHALL ignore istart in RUN and DONE, with no queuing and no restart.
REQ-018 SHALL NOT let ikey/iblock changes after acceptance affect the result.
REQ-019 SHALL hold oblock stable in IDLE and change it only at round 31 completion.
REQ-020 SHALL let rnd wrap 31->0 without harm, since the FSM exits at 31.

Reset
REQ-021 SHALL, on irst=1 at a rising edge, go to IDLE and clear rnd, odone, obusy, oblock, the state register and the key register to 0.
REQ-022 SHALL let irst abort a decryption in progress, with no odone produced.
REQ-023 SHALL make irst take priority over istart in the same cycle.

Structure
REQ-024 SHALL keep the S-box table (GOST R 34.12-2015 Magma set, 8x16x4-bit) and the round-count/rotate constants in shared package gost_pkg, also used by the encrypt path.
REQ-025 SHALL use one combinational sub-module gost_round_f computing g(x) from the 32-bit half and the 32-bit key.
REQ-026 SHALL compute key selection from rnd combinationally with no key-expansion memory.

Verification
REQ-027 SHALL cover the standard vector: ikey=ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, iblock=4ee901e5c2d8ca3d, istart pulse -> odone 33 cycles later with oblock=fedcba9876543210.
REQ-028 SHALL cover a round-trip: 16 random key/block pairs encrypted by the existing round model, fed here -> each oblock equals the original plaintext.
REQ-029 SHALL cover istart held high for 40 cycles -> exactly one odone at cycle 33, and a second accepted start at cycle 34 with odone at cycle 67.
REQ-030 SHALL cover irst asserted at rnd=15 -> no odone, obusy=0 and oblock=0 on the next cycle, and a fresh vector after release decrypts correctly.
REQ-031 SHALL cover iblock/ikey changed to all-ones during RUN -> oblock=fedcba9876543210 unchanged.
REQ-032 SHALL cover irst and istart high in the same cycle -> stays IDLE with obusy=0.
